ternary_serial_adder_ctrl: RTL and testbench

- Digit-serial controller that sequences one ternary digit adder slice across an NDIG-digit operand pair.
- Processes one digit per clock, least significant digit first, with the carry held in a register between digits.
- Supports ternary add, and subtract via digit complement plus carry-in.
- Sits between a requester (start/done handshake) and the ternary arithmetic datapath.
- Digit encoding throughout is 2'b00=0, 2'b01=1, 2'b10=2; 2'b11 is invalid.

---
 rtl/ternary_serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_ternary_serial_adder_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_serial_adder_ctrl.sv
// Digit-serial ternary add/subtract controller: one digit per clock, LSD first,
// with the inter-digit carry held in a register and a start/done handshake.
module ternary_serial_adder_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic              cin,
  input  logic [2*NDIG-1:0] A,
  input  logic [2*NDIG-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [2*NDIG-1:0] S,
  output logic              Cout,
  output logic              err
);

  localparam int W  = 2 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic [W-1:0]    b_cmp;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [1:0]      a_dig, b_dig, sum_dig;
  logic [2:0]      t;
  logic            dig_bad, last;

  // Subtraction uses the digitwise complement (2-d); invalid 11 passes through
  // unchanged so it is still flagged while running.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_cmp
      assign b_cmp[2*gi +: 2] = (B[2*gi +: 2] == 2'b11) ? 2'b11 : (2'd2 - B[2*gi +: 2]);
    end
  endgenerate

  assign a_dig   = a_q[2*cnt_q +: 2];
  assign b_dig   = b_q[2*cnt_q +: 2];
  assign t       = {1'b0, a_dig} + {1'b0, b_dig} + {2'b00, carry_q};
  assign sum_dig = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  assign dig_bad = (&a_dig) | (&b_dig);
  assign last    = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = op ? b_cmp : B;
          carry_d = op ? 1'b1 : cin;
          cnt_d   = '0;
          s_d     = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        s_d[2*cnt_q +: 2] = sum_dig;
        carry_d = (t >= 3'd3);
        err_d   = err_q | dig_bad;
        if (last) begin
          // An invalid digit anywhere squashes the whole result on the way into DONE.
          if (err_q | dig_bad) begin
            s_d    = '0;
            cout_d = 1'b0;
          end else begin
            cout_d = (t >= 3'd3);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ternary_serial_adder_ctrl.sv
// Self-checking bench for ternary_serial_adder_ctrl: vector table plus
// hand-written protocol sequences, results checked through a scoreboard queue.
module tb_ternary_serial_adder_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 2 * NDIG;
  localparam int NV   = 16;

  typedef struct {
    logic         op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
    logic         e;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Cout, err;
  logic [W-1:0] S;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  ternary_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Integer reference: operands converted to numbers, result converted back.
  function automatic exp_t model(input logic op_m, input logic cin_m,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    int av = 0, bv = 0, m = 1, res;
    r.e = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a[2*i +: 2] == 2'b11 || b[2*i +: 2] == 2'b11) r.e = 1'b1;
      av += int'(a[2*i +: 2]) * m;
      bv += int'(b[2*i +: 2]) * m;
      m  *= 3;
    end
    res  = op_m ? (av + (m - 1 - bv) + 1) : (av + bv + int'(cin_m));
    r.co = (res >= m);
    res  = res % m;
    for (int i = 0; i < NDIG; i++) begin
      r.s[2*i +: 2] = 2'(res % 3);
      res = res / 3;
    end
    if (r.e) begin
      r.s  = '0;
      r.co = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("S", 32'(S), 32'(x.s));
        chk("Cout", 32'(Cout), 32'(x.co));
        chk("err", 32'(err), 32'(x.e));
        $display("op done: S=%h Cout=%0d err=%0d (expected S=%h Cout=%0d err=%0d)",
                 S, Cout, err, x.s, x.co, x.e);
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t x;
    x.s = v.s; x.co = v.co; x.e = v.e;
    sb.push_back(x);
  endtask

  // Drive one operation from IDLE and check latency and busy length.
  task automatic run_op(input vec_t v);
    int lat = 0, bcnt = 0;
    @(negedge clk);
    op = v.op; cin = v.cin; A = v.a; B = v.b; start = 1'b1;
    push_exp(v);
    do begin
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 30);
    chk("latency", 32'(lat), 32'(NDIG + 1));
    chk("busy_cycles", 32'(bcnt), 32'(NDIG));
  endtask

  task automatic set_vec(input int i, input logic o, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic co, input logic e);
    vecs[i].op = o; vecs[i].cin = c; vecs[i].a = a; vecs[i].b = b;
    vecs[i].s = s; vecs[i].co = co; vecs[i].e = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 1'b0, 1'b0, 8'h14, 8'h09, 8'h21, 1'b0, 1'b0);
    set_vec(1, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b1, 1'b0);
    set_vec(2, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'hA9, 1'b1, 1'b0);
    set_vec(3, 1'b1, 1'b0, 8'h14, 8'h09, 8'h06, 1'b1, 1'b0);
    set_vec(4, 1'b1, 1'b0, 8'h09, 8'h14, 8'hA5, 1'b0, 1'b0);
    set_vec(5, 1'b0, 1'b0, 8'h03, 8'h01, 8'h00, 1'b0, 1'b1);
    set_vec(6, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    set_vec(7, 1'b1, 1'b1, 8'h14, 8'h14, 8'h00, 1'b1, 1'b0);
    set_vec(8, 1'b1, 1'b0, 8'h00, 8'h0C, 8'h00, 1'b0, 1'b1);
    set_vec(9, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
    for (int i = 10; i < NV; i++) begin
      exp_t x;
      vecs[i].op  = 1'($urandom_range(0, 1));
      vecs[i].cin = 1'($urandom_range(0, 1));
      for (int d = 0; d < NDIG; d++) begin
        vecs[i].a[2*d +: 2] = 2'($urandom_range(0, 2));
        vecs[i].b[2*d +: 2] = 2'($urandom_range(0, 2));
      end
      x = model(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b);
      vecs[i].s = x.s; vecs[i].co = x.co; vecs[i].e = x.e;
    end

    // Reset, then idle with no start.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_outputs", {busy, done, Cout, err, S}, 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i]);
      @(negedge clk);
      chk("hold_S", 32'(S), 32'(vecs[i].s));
      chk("hold_err", 32'(err), 32'(vecs[i].e));
    end

    // start re-pulsed during RUN with other operands is ignored.
    begin
      vec_t v;
      int lat = 0;
      v = vecs[0];
      @(negedge clk);
      op = 1'b0; cin = 1'b0; A = 8'h14; B = 8'h09; start = 1'b1;
      push_exp(v);
      @(negedge clk); start = 1'b0; lat++;
      @(negedge clk); start = 1'b1; A = 8'h22; B = 8'h22; op = 1'b1; lat++;
      @(negedge clk); lat++;
      start = 1'b0;
      while (!done && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      chk("repulse_latency", 32'(lat), 32'(NDIG + 1));
      repeat (2 * (NDIG + 2)) @(negedge clk);
    end

    // Reset asserted while digit 2 is being processed aborts without done.
    @(negedge clk);
    op = 1'b0; cin = 1'b1; A = 8'hAA; B = 8'hAA; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, Cout, err, S}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NDIG + 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {busy, done}, 32'd0);
    end

    // start held high: back-to-back operations every NDIG+2 cycles.
    begin
      int t_done[3];
      int n = 0, guard = 0;
      @(negedge clk);
      op = 1'b0; cin = 1'b0; A = 8'h14; B = 8'h09; start = 1'b1;
      for (int i = 0; i < 3; i++) push_exp(vecs[0]);
      while (n < 3 && guard < 100) begin
        @(negedge clk);
        guard++;
        if (done) begin
          t_done[n] = cyc;
          n++;
          if (n == 3) start = 1'b0;
        end
      end
      chk("held_start_ops", 32'(n), 32'd3);
      if (n == 3) begin
        chk("spacing_1", 32'(t_done[1] - t_done[0]), 32'(NDIG + 2));
        chk("spacing_2", 32'(t_done[2] - t_done[1]), 32'(NDIG + 2));
      end
      repeat (2 * (NDIG + 2)) @(negedge clk);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
